mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum MEM-state wait, in cycles, for MemRdy before abort.
REQ-002 Clk  input  1  SHALL be the single clock; all state changes occur on the rising edge.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 opcode  input  6  SHALL carry the instruction-register bits [31:26].
REQ-005 funct  input  6  SHALL carry the instruction-register bits [5:0].
REQ-006 Zero  input  1  SHALL carry the ALU zero flag.
REQ-007 MemRdy  input  1  SHALL carry the data-memory completion handshake.
REQ-008 PCWr, IRWr, RegWr, MemWr, MemRd  output  1 each  SHALL be the write and read strobes.
REQ-009 RegDst, ExtOp, ALUSrc, MemtoReg, nPC_sel, Jump  output  1 each  SHALL be the datapath mux selects.
REQ-010 ALUctr  output  3  SHALL be the ALU operation code.
REQ-011 Illegal, MemErr  output  1 each  SHALL be one-cycle error pulses.
REQ-012 InstrCnt  output  32  SHALL be the retired-instruction count.
REQ-013 State  output  3  SHALL expose the current FSM state for debug.

Function
REQ-014 States: IDLE, FETCH, DECODE, EXEC, MEM, WB; IDLE SHALL be entered only from reset and SHALL exit to FETCH after 1 cycle.
REQ-015 FETCH SHALL assert IRWr=1 and PCWr=1 with nPC_sel=0 and Jump=0 (PC+4), then go to DECODE.
REQ-016 DECODE: for j (000010), the block SHALL assert PCWr=1 and Jump=1, retire the instruction, and go to FETCH.
REQ-017 DECODE: for an unsupported opcode/funct, the block SHALL pulse Illegal, assert no strobe, not retire, and go to FETCH.
REQ-018 Supported instructions SHALL be addu (0/100001), subu (0/100011), ori (001101), lui (001111), lw (100011), sw (101011), beq (000100) and j.
REQ-019 EXEC SHALL hold ALUctr and ALUSrc per instruction: ADD=000 for addu/lw/sw; SUB=001 for subu/beq; OR=010 for ori; LUI=011 for lui.
REQ-020 EXEC for ALUSrc/ExtOp: ALUSrc=1 for ori/lui/lw/sw; ExtOp=1 (sign-extend) for lw/sw/beq; ExtOp=0 for ori/lui.
REQ-021 EXEC for beq: the block SHALL assert PCWr=1 with nPC_sel=1 only when Zero=1, retire, and go to FETCH.
REQ-022 EXEC for R-type/ori/lui SHALL go to WB; for lw/sw it SHALL go to MEM.
REQ-023 MEM SHALL hold MemRd=1 (lw) or MemWr=1 (sw) every cycle until MemRdy=1 is sampled; the MEM state SHALL last at least 1 cycle.
REQ-024 MEM on MemRdy=1: lw SHALL go to WB; sw SHALL retire and go to FETCH.
REQ-025 MEM timeout: if MemRdy is still 0 after MEM_TIMEOUT cycles, the block SHALL drop the strobe, pulse MemErr, not retire, and go to FETCH; the wait counter SHALL clear on every MEM entry.
REQ-026 WB SHALL assert RegWr=1 with RegDst=1 for R-type and 0 otherwise, and MemtoReg=1 for lw only; it SHALL retire and go to FETCH.
REQ-027 Retire SHALL increment InstrCnt by 1 on that edge; InstrCnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 All strobes not named for a state SHALL be 0 in that state; outputs SHALL be decoded from registered state and the registered opcode/funct class.
REQ-029 CPI SHALL be: j=2, beq=3, R/ori/lui=4, sw=4+waits, lw=5+waits.

Reset
REQ-030 Reset=0 SHALL immediately force State=IDLE, InstrCnt=0, the wait counter to 0, and all strobes and pulses to 0, including mid-MEM.
REQ-031 In IDLE all outputs SHALL be 0, so that no PC or IR write occurs in the first post-reset cycle.

Structure
REQ-032 State encodings, ALUctr codes, opcode/funct constants and MEM_TIMEOUT default SHALL live in a shared package, mips_pkg.
REQ-033 Opcode/funct classification SHALL be one combinational sub-module, mc_decode, instantiated once.

Verification
REQ-034 Release reset, opcode=0/funct=100001 -> IDLE,FETCH,DECODE,EXEC,WB; RegWr=1 and RegDst=1 in WB only; InstrCnt=1.
REQ-035 lw with MemRdy high on the 3rd MEM cycle -> MemRd=1 for 3 cycles, then WB with MemtoReg=1; total 7 cycles.
REQ-036 sw with MemRdy=0 held -> MemWr=1 for 15 cycles, MemErr pulse, FETCH; InstrCnt unchanged.
REQ-037 beq with Zero=1 -> PCWr=1 and nPC_sel=1 in EXEC; with Zero=0 -> PCWr=0; both take 3 cycles.
REQ-038 opcode=111111 -> Illegal pulse in DECODE, no strobes, FETCH next.
REQ-039 Reset asserted mid-MEM -> MemWr=0 immediately, State=IDLE, InstrCnt=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encodings,
// instruction classes, ALU operation codes, opcode/funct constants and the
// default MEM-state timeout.
package mips_pkg;

  localparam int MEM_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_ADDU = 4'd0,
    CLS_SUBU = 4'd1,
    CLS_ORI  = 4'd2,
    CLS_LUI  = 4'd3,
    CLS_LW   = 4'd4,
    CLS_SW   = 4'd5,
    CLS_BEQ  = 4'd6,
    CLS_J    = 4'd7,
    CLS_ILL  = 4'd8
  } instr_cls_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  function automatic logic is_rtype(input instr_cls_e cls);
    return (cls == CLS_ADDU) || (cls == CLS_SUBU);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle.
//   master : the controller (samples opcode/funct/Zero/MemRdy, drives the rest)
//   slave  : the datapath/memory side
// Signals:
//   opcode, funct   instruction-register fields [31:26] and [5:0]
//   Zero            ALU zero flag
//   MemRdy          data-memory completion handshake
//   PCWr..MemRd     write/read strobes
//   RegDst..Jump    datapath mux selects
//   ALUctr          ALU operation code
//   Illegal, MemErr one-cycle error pulses
//   InstrCnt        retired-instruction count
//   State           current FSM state (debug)
interface mc_controller_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        Zero;
  logic        MemRdy;
  logic        PCWr;
  logic        IRWr;
  logic        RegWr;
  logic        MemWr;
  logic        MemRd;
  logic        RegDst;
  logic        ExtOp;
  logic        ALUSrc;
  logic        MemtoReg;
  logic        nPC_sel;
  logic        Jump;
  logic [2:0]  ALUctr;
  logic        Illegal;
  logic        MemErr;
  logic [31:0] InstrCnt;
  logic [2:0]  State;

  modport master (
    input  opcode, funct, Zero, MemRdy,
    output PCWr, IRWr, RegWr, MemWr, MemRd,
    output RegDst, ExtOp, ALUSrc, MemtoReg, nPC_sel, Jump,
    output ALUctr, Illegal, MemErr, InstrCnt, State
  );

  modport slave (
    output opcode, funct, Zero, MemRdy,
    input  PCWr, IRWr, RegWr, MemWr, MemRd,
    input  RegDst, ExtOp, ALUSrc, MemtoReg, nPC_sel, Jump,
    input  ALUctr, Illegal, MemErr, InstrCnt, State
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier.
//   opcode, funct : instruction fields
//   cls           : instruction class; CLS_ILL for anything unsupported
module mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_cls_e cls
);

  always_comb begin
    cls = CLS_ILL;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls = CLS_ADDU;
        else if (funct == FN_SUBU) cls = CLS_SUBU;
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      default: cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM.
//   Clk   : clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : controller side of mc_controller_if (see interface for signals)
//
// state  | meaning
// IDLE   | first cycle after reset, all outputs low
// FETCH  | IR write and PC <= PC+4
// DECODE | j completes here; unsupported instructions flag Illegal
// EXEC   | ALU operation; beq completes here
// MEM    | load/store strobe held until MemRdy or timeout
// WB     | register-file write
module mc_controller
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic               Clk,
  input logic               Reset,
  mc_controller_if.master   bus
);

  localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e      state_q, state_d;
  instr_cls_e  cls_d, cls_q;
  logic [WW-1:0] wait_q;
  logic [31:0] instr_cnt_q;
  logic        retire;
  logic        timed_out;

  logic        pc_wr, ir_wr, reg_wr, mem_wr, mem_rd;
  logic        reg_dst, ext_op, alu_src, mem_to_reg, npc_sel, jump;
  logic [2:0]  alu_ctr;
  logic        illegal, mem_err;

  mc_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .cls    (cls_d)
  );

  assign timed_out = (wait_q == WW'(MEM_TIMEOUT));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      cls_q       <= CLS_ILL;
      wait_q      <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      // The IR is loaded in FETCH, so its class is captured on that edge.
      if (state_q == S_FETCH) cls_q <= cls_d;
      // Counts only while staying in MEM, so every MEM entry starts at zero.
      if (state_q == S_MEM && state_d == S_MEM) wait_q <= wait_q + 1'b1;
      else                                      wait_q <= '0;
      if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    reg_dst    = 1'b0;
    ext_op     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    npc_sel    = 1'b0;
    jump       = 1'b0;
    alu_ctr    = ALU_ADD;
    illegal    = 1'b0;
    mem_err    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        case (cls_q)
          CLS_J: begin
            pc_wr   = 1'b1;
            jump    = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          CLS_ILL: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (cls_q)
          CLS_ADDU: begin
            alu_ctr = ALU_ADD;
            state_d = S_WB;
          end
          CLS_SUBU: begin
            alu_ctr = ALU_SUB;
            state_d = S_WB;
          end
          CLS_ORI: begin
            alu_ctr = ALU_OR;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          CLS_LUI: begin
            alu_ctr = ALU_LUI;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          CLS_LW, CLS_SW: begin
            alu_ctr = ALU_ADD;
            alu_src = 1'b1;
            ext_op  = 1'b1;
            state_d = S_MEM;
          end
          CLS_BEQ: begin
            alu_ctr = ALU_SUB;
            ext_op  = 1'b1;
            pc_wr   = bus.Zero;
            npc_sel = bus.Zero;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        if (timed_out) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          mem_rd = (cls_q == CLS_LW);
          mem_wr = (cls_q == CLS_SW);
          if (bus.MemRdy) begin
            if (cls_q == CLS_LW) begin
              state_d = S_WB;
            end else begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end
        end
      end

      S_WB: begin
        reg_wr     = 1'b1;
        reg_dst    = is_rtype(cls_q);
        mem_to_reg = (cls_q == CLS_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.PCWr     = pc_wr;
  assign bus.IRWr     = ir_wr;
  assign bus.RegWr    = reg_wr;
  assign bus.MemWr    = mem_wr;
  assign bus.MemRd    = mem_rd;
  assign bus.RegDst   = reg_dst;
  assign bus.ExtOp    = ext_op;
  assign bus.ALUSrc   = alu_src;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.nPC_sel  = npc_sel;
  assign bus.Jump     = jump;
  assign bus.ALUctr   = alu_ctr;
  assign bus.Illegal  = illegal;
  assign bus.MemErr   = mem_err;
  assign bus.InstrCnt = instr_cnt_q;
  assign bus.State    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
module tb_mc_controller;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5;
  // strb = {PCWr, IRWr, RegWr, MemWr, MemRd, Illegal, MemErr}
  // sel  = {RegDst, ExtOp, ALUSrc, MemtoReg, nPC_sel, Jump}
  localparam logic [6:0] STRB_FETCH = 7'b1100000;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic [6:0] strb;
  logic [5:0] sel;

  mc_controller_if bus ();

  mc_controller #(.MEM_TIMEOUT(15)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  assign strb = {bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.MemRd, bus.Illegal, bus.MemErr};
  assign sel  = {bus.RegDst, bus.ExtOp, bus.ALUSrc, bus.MemtoReg, bus.nPC_sel, bus.Jump};

  task automatic tick;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset;
    bus.opcode = 6'h00;
    bus.funct  = 6'h21;
    bus.Zero   = 1'b0;
    bus.MemRdy = 1'b0;
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.State !== ST_IDLE || strb !== 7'd0 || sel !== 6'd0 || bus.ALUctr !== 3'd0 || bus.InstrCnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold: got state=%0d strb=%b sel=%b alu=%b cnt=%0d want state=0 all zero",
               bus.State, strb, sel, bus.ALUctr, bus.InstrCnt);
    end
    @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    checks++;
    if (bus.State !== ST_IDLE || strb !== 7'd0 || sel !== 6'd0) begin
      errors++;
      $display("FAIL idle_after_release: got state=%0d strb=%b sel=%b want state=0 strb=0 sel=0",
               bus.State, strb, sel);
    end
  endtask

  task automatic test_addu;
    tick;
    checks++;
    if (bus.State !== ST_FETCH || strb !== STRB_FETCH || sel !== 6'd0) begin
      errors++;
      $display("FAIL addu_fetch: got state=%0d strb=%b sel=%b want state=1 strb=1100000 sel=000000",
               bus.State, strb, sel);
    end
    tick;
    checks++;
    if (bus.State !== ST_DECODE || strb !== 7'd0) begin
      errors++;
      $display("FAIL addu_decode: got state=%0d strb=%b want state=2 strb=0000000", bus.State, strb);
    end
    tick;
    checks++;
    if (bus.State !== ST_EXEC || strb !== 7'd0 || sel !== 6'd0 || bus.ALUctr !== 3'b000) begin
      errors++;
      $display("FAIL addu_exec: got state=%0d strb=%b sel=%b alu=%b want state=3 strb=0 sel=0 alu=000",
               bus.State, strb, sel, bus.ALUctr);
    end
    tick;
    checks++;
    if (bus.State !== ST_WB || strb !== 7'b0010000 || sel !== 6'b100000) begin
      errors++;
      $display("FAIL addu_wb: got state=%0d strb=%b sel=%b want state=5 strb=0010000 sel=100000",
               bus.State, strb, sel);
    end
    tick;
    exp_cnt = 32'd1;
    checks++;
    if (bus.State !== ST_FETCH || bus.InstrCnt !== exp_cnt) begin
      errors++;
      $display("FAIL addu_retire: got state=%0d cnt=%0d want state=1 cnt=%0d", bus.State, bus.InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_alu_ops;
    logic [5:0] op_t [3];
    logic [5:0] fn_t [3];
    logic [2:0] alu_t [3];
    logic [5:0] xsel_t [3];
    logic [5:0] wsel_t [3];
    op_t   = '{6'h00, 6'h0D, 6'h0F};
    fn_t   = '{6'h23, 6'h21, 6'h00};
    alu_t  = '{3'b001, 3'b010, 3'b011};
    xsel_t = '{6'b000000, 6'b001000, 6'b001000};
    wsel_t = '{6'b100000, 6'b000000, 6'b000000};
    for (int i = 0; i < 3; i++) begin
      bus.opcode = op_t[i];
      bus.funct  = fn_t[i];
      tick;
      tick;
      checks++;
      if (bus.State !== ST_EXEC || bus.ALUctr !== alu_t[i] || sel !== xsel_t[i] || strb !== 7'd0) begin
        errors++;
        $display("FAIL alu_exec[%0d]: got state=%0d alu=%b sel=%b strb=%b want state=3 alu=%b sel=%b strb=0000000",
                 i, bus.State, bus.ALUctr, sel, strb, alu_t[i], xsel_t[i]);
      end
      tick;
      checks++;
      if (bus.State !== ST_WB || strb !== 7'b0010000 || sel !== wsel_t[i]) begin
        errors++;
        $display("FAIL alu_wb[%0d]: got state=%0d strb=%b sel=%b want state=5 strb=0010000 sel=%b",
                 i, bus.State, strb, sel, wsel_t[i]);
      end
      tick;
      exp_cnt++;
      checks++;
      if (bus.State !== ST_FETCH || bus.InstrCnt !== exp_cnt) begin
        errors++;
        $display("FAIL alu_retire[%0d]: got state=%0d cnt=%0d want state=1 cnt=%0d",
                 i, bus.State, bus.InstrCnt, exp_cnt);
      end
    end
  endtask

  task automatic test_lw;
    bus.opcode = 6'h23;
    bus.funct  = 6'h00;
    bus.MemRdy = 1'b0;
    tick;
    tick;
    checks++;
    if (bus.State !== ST_EXEC || bus.ALUctr !== 3'b000 || sel !== 6'b011000) begin
      errors++;
      $display("FAIL lw_exec: got state=%0d alu=%b sel=%b want state=3 alu=000 sel=011000", bus.State, bus.ALUctr, sel);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (bus.State !== ST_MEM || strb !== 7'b0000100) begin
        errors++;
        $display("FAIL lw_mem[%0d]: got state=%0d strb=%b want state=4 strb=0000100", i, bus.State, strb);
      end
      if (i == 2) bus.MemRdy = 1'b1;
    end
    tick;
    bus.MemRdy = 1'b0;
    checks++;
    if (bus.State !== ST_WB || strb !== 7'b0010000 || sel !== 6'b000100) begin
      errors++;
      $display("FAIL lw_wb: got state=%0d strb=%b sel=%b want state=5 strb=0010000 sel=000100", bus.State, strb, sel);
    end
    tick;
    exp_cnt++;
    checks++;
    if (bus.State !== ST_FETCH || bus.InstrCnt !== exp_cnt) begin
      errors++;
      $display("FAIL lw_retire: got state=%0d cnt=%0d want state=1 cnt=%0d", bus.State, bus.InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_sw_timeout;
    int n;
    bus.opcode = 6'h2B;
    bus.MemRdy = 1'b0;
    tick;
    tick;
    checks++;
    if (bus.State !== ST_EXEC || sel !== 6'b011000 || bus.ALUctr !== 3'b000) begin
      errors++;
      $display("FAIL sw_exec: got state=%0d sel=%b alu=%b want state=3 sel=011000 alu=000", bus.State, sel, bus.ALUctr);
    end
    tick;
    n = 0;
    for (int g = 0; g < 40; g++) begin
      if (bus.State == ST_MEM && strb == 7'b0001000) begin
        n++;
        tick;
      end else begin
        break;
      end
    end
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL sw_timeout_len: got %0d MemWr cycles want 15", n);
    end
    checks++;
    if (bus.State !== ST_MEM || strb !== 7'b0000001) begin
      errors++;
      $display("FAIL sw_memerr: got state=%0d strb=%b want state=4 strb=0000001", bus.State, strb);
    end
    tick;
    checks++;
    if (bus.State !== ST_FETCH || strb !== STRB_FETCH || bus.InstrCnt !== exp_cnt) begin
      errors++;
      $display("FAIL sw_timeout_exit: got state=%0d strb=%b cnt=%0d want state=1 strb=1100000 cnt=%0d",
               bus.State, strb, bus.InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_sw_late_ready;
    int bad;
    bus.opcode = 6'h2B;
    bus.MemRdy = 1'b0;
    tick;
    tick;
    tick;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.State !== ST_MEM || strb !== 7'b0001000) bad++;
      if (i == 14) bus.MemRdy = 1'b1;
      tick;
    end
    bus.MemRdy = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL sw_late_mem: got %0d bad MEM cycles want 0", bad);
    end
    exp_cnt++;
    checks++;
    if (bus.State !== ST_FETCH || bus.InstrCnt !== exp_cnt) begin
      errors++;
      $display("FAIL sw_late_retire: got state=%0d cnt=%0d want state=1 cnt=%0d", bus.State, bus.InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_beq;
    bus.opcode = 6'h04;
    bus.Zero   = 1'b1;
    tick;
    tick;
    checks++;
    if (bus.State !== ST_EXEC || strb !== 7'b1000000 || sel !== 6'b010010 || bus.ALUctr !== 3'b001) begin
      errors++;
      $display("FAIL beq_taken: got state=%0d strb=%b sel=%b alu=%b want state=3 strb=1000000 sel=010010 alu=001",
               bus.State, strb, sel, bus.ALUctr);
    end
    tick;
    exp_cnt++;
    checks++;
    if (bus.State !== ST_FETCH || bus.InstrCnt !== exp_cnt) begin
      errors++;
      $display("FAIL beq_taken_retire: got state=%0d cnt=%0d want state=1 cnt=%0d", bus.State, bus.InstrCnt, exp_cnt);
    end
    bus.Zero = 1'b0;
    tick;
    tick;
    checks++;
    if (bus.State !== ST_EXEC || strb !== 7'd0 || bus.ALUctr !== 3'b001) begin
      errors++;
      $display("FAIL beq_not_taken: got state=%0d strb=%b alu=%b want state=3 strb=0000000 alu=001",
               bus.State, strb, bus.ALUctr);
    end
    tick;
    exp_cnt++;
    checks++;
    if (bus.State !== ST_FETCH || bus.InstrCnt !== exp_cnt) begin
      errors++;
      $display("FAIL beq_nt_retire: got state=%0d cnt=%0d want state=1 cnt=%0d", bus.State, bus.InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_jump;
    bus.opcode = 6'h02;
    tick;
    checks++;
    if (bus.State !== ST_DECODE || strb !== 7'b1000000 || sel !== 6'b000001) begin
      errors++;
      $display("FAIL j_decode: got state=%0d strb=%b sel=%b want state=2 strb=1000000 sel=000001", bus.State, strb, sel);
    end
    tick;
    exp_cnt++;
    checks++;
    if (bus.State !== ST_FETCH || bus.InstrCnt !== exp_cnt) begin
      errors++;
      $display("FAIL j_retire: got state=%0d cnt=%0d want state=1 cnt=%0d", bus.State, bus.InstrCnt, exp_cnt);
    end
  endtask

  task automatic test_illegal;
    logic [5:0] op_t [2];
    logic [5:0] fn_t [2];
    op_t = '{6'h3F, 6'h00};
    fn_t = '{6'h00, 6'h20};
    for (int i = 0; i < 2; i++) begin
      bus.opcode = op_t[i];
      bus.funct  = fn_t[i];
      tick;
      checks++;
      if (bus.State !== ST_DECODE || strb !== 7'b0000010 || sel !== 6'd0) begin
        errors++;
        $display("FAIL illegal_decode[%0d]: got state=%0d strb=%b sel=%b want state=2 strb=0000010 sel=000000",
                 i, bus.State, strb, sel);
      end
      tick;
      checks++;
      if (bus.State !== ST_FETCH || strb !== STRB_FETCH || bus.InstrCnt !== exp_cnt) begin
        errors++;
        $display("FAIL illegal_exit[%0d]: got state=%0d strb=%b cnt=%0d want state=1 strb=1100000 cnt=%0d",
                 i, bus.State, strb, bus.InstrCnt, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_mem;
    bus.opcode = 6'h2B;
    bus.funct  = 6'h00;
    bus.MemRdy = 1'b0;
    tick;
    tick;
    tick;
    tick;
    checks++;
    if (bus.State !== ST_MEM || bus.MemWr !== 1'b1) begin
      errors++;
      $display("FAIL midmem_setup: got state=%0d MemWr=%b want state=4 MemWr=1", bus.State, bus.MemWr);
    end
    #2 Reset = 1'b0;
    #1;
    exp_cnt = 32'd0;
    checks++;
    if (bus.MemWr !== 1'b0 || bus.State !== ST_IDLE || bus.InstrCnt !== exp_cnt || strb !== 7'd0) begin
      errors++;
      $display("FAIL midmem_reset: got state=%0d MemWr=%b strb=%b cnt=%0d want state=0 MemWr=0 strb=0 cnt=0",
               bus.State, bus.MemWr, strb, bus.InstrCnt);
    end
    @(negedge Clk);
    checks++;
    if (bus.State !== ST_IDLE || strb !== 7'd0) begin
      errors++;
      $display("FAIL midmem_hold: got state=%0d strb=%b want state=0 strb=0", bus.State, strb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_addu;
    test_alu_ops;
    test_lw;
    test_sw_timeout;
    test_sw_late_ready;
    test_beq;
    test_jump;
    test_illegal;
    test_reset_mid_mem;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
